commit_trace_buffer: RTL and testbench

//  Downstream of the processor core's commit/writeback point. Each cycle it samples the retire-side signals
//  (PC, instruction, register write, memory access, halt) and classifies them into trace records.
//  It numbers each record (INUM) and buffers records in a FIFO drained by a ready/valid consumer (trace writer, bench).
//  It stops capturing on halt and signals done once the buffer has fully drained.

---
 rtl/commit_trace_buffer.sv | 197 +++++++++++++++++++
 tb/tb_commit_trace_buffer.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: classifies retiring instructions into numbered trace records and queues them for a consumer.
// Optional per-record cycle stamping is enabled by defining COMMIT_TRACE_CYCLE_EN.
module commit_trace_buffer #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cm_valid,
    input  logic [15:0]      cm_pc,
    input  logic [15:0]      cm_inst,
    input  logic             cm_regwrt,
    input  logic [2:0]       cm_wrreg,
    input  logic [15:0]      cm_wrdata,
    input  logic             cm_memrd,
    input  logic             cm_memwrt,
    input  logic [15:0]      cm_memaddr,
    input  logic [15:0]      cm_memdata,
    input  logic             cm_halt,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [2:0]       rec_kind,
    output logic [CNT_W-1:0] rec_inum,
    output logic [15:0]      rec_pc,
    output logic [2:0]       rec_reg,
    output logic [15:0]      rec_wdata,
    output logic [15:0]      rec_addr,
    output logic [15:0]      rec_mdata,
    output logic [31:0]      rec_cycle,
    output logic [CNT_W-1:0] inst_count,
    output logic             overflow,
    output logic             err,
    output logic             done
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    localparam logic [2:0] K_REG     = 3'd0;
    localparam logic [2:0] K_LD      = 3'd1;
    localparam logic [2:0] K_STU     = 3'd2;
    localparam logic [2:0] K_ST      = 3'd3;
    localparam logic [2:0] K_NOP     = 3'd4;
    localparam logic [2:0] K_HALT    = 3'd5;
    localparam logic [2:0] K_ILLEGAL = 3'd7;

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [2:0]       kind;
        logic [CNT_W-1:0] inum;
        logic [15:0]      pc;
        logic [2:0]       rg;
        logic [15:0]      wdata;
        logic [15:0]      addr;
        logic [15:0]      mdata;
`ifdef COMMIT_TRACE_CYCLE_EN
        logic [31:0]      cycle;
`endif
    } rec_t;

    state_t         state, state_next;
    rec_t           mem [DEPTH];
    rec_t           new_rec, last_rec, head;
    logic [AW-1:0]  wptr, rptr;
    logic [AW:0]    count, count_next;
    logic           capture, full, empty, push, pop, drop;
    logic           unused_inst;

    assign unused_inst = ^cm_inst;

`ifdef COMMIT_TRACE_CYCLE_EN
    logic [31:0] cycle_cnt;

    always_ff @(posedge clk) begin
        if (rst) cycle_cnt <= '0;
        else     cycle_cnt <= cycle_cnt + 32'd1;
    end
`endif

    // Priority classification; fields a record kind does not use are stored as zero.
    always_comb begin
        new_rec      = '0;
        new_rec.pc   = cm_pc;
        new_rec.inum = inst_count;
`ifdef COMMIT_TRACE_CYCLE_EN
        new_rec.cycle = cycle_cnt;
`endif
        if (cm_halt) begin
            new_rec.kind = K_HALT;
        end else if (cm_memrd && cm_memwrt) begin
            new_rec.kind = K_ILLEGAL;
        end else if (cm_regwrt && cm_memwrt) begin
            new_rec.kind  = K_STU;
            new_rec.rg    = cm_wrreg;
            new_rec.wdata = cm_wrdata;
            new_rec.addr  = cm_memaddr;
            new_rec.mdata = cm_memdata;
        end else if (cm_regwrt && cm_memrd) begin
            new_rec.kind  = K_LD;
            new_rec.rg    = cm_wrreg;
            new_rec.wdata = cm_wrdata;
            new_rec.addr  = cm_memaddr;
        end else if (cm_regwrt) begin
            new_rec.kind  = K_REG;
            new_rec.rg    = cm_wrreg;
            new_rec.wdata = cm_wrdata;
        end else if (cm_memwrt) begin
            new_rec.kind  = K_ST;
            new_rec.addr  = cm_memaddr;
            new_rec.mdata = cm_memdata;
        end else begin
            new_rec.kind = K_NOP;
        end
    end

    assign capture = (state == RUN) && cm_valid;
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign pop     = !empty && rec_ready;
    // A full FIFO still accepts a push when the head is leaving in the same cycle.
    assign push    = capture && (!full || pop);
    assign drop    = capture && full && !pop;

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= new_rec;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            inst_count <= '0;
            overflow   <= 1'b0;
            err        <= 1'b0;
            last_rec   <= '0;
        end else begin
            count <= count_next;
            if (push) begin
                wptr       <= wptr + 1'b1;
                inst_count <= inst_count + 1'b1;
                if (new_rec.kind == K_ILLEGAL) err <= 1'b1;
            end
            if (pop) begin
                rptr     <= rptr + 1'b1;
                last_rec <= mem[rptr];
            end
            if (drop) overflow <= 1'b1;
        end
    end

    // An empty FIFO keeps presenting the most recently consumed record.
    assign head      = empty ? last_rec : mem[rptr];
    assign rec_valid = !empty;
    assign rec_kind  = head.kind;
    assign rec_inum  = head.inum;
    assign rec_pc    = head.pc;
    assign rec_reg   = head.rg;
    assign rec_wdata = head.wdata;
    assign rec_addr  = head.addr;
    assign rec_mdata = head.mdata;
`ifdef COMMIT_TRACE_CYCLE_EN
    assign rec_cycle = head.cycle;
`else
    assign rec_cycle = 32'd0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_next;
    end

    // A halt ends capture even if its record was dropped on a full FIFO.
    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (capture && cm_halt) state_next = DRAIN;
            DRAIN:   if (count_next == '0)   state_next = DONE;
            DONE:    state_next = DONE;
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        done = (state == DONE);
    end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Self-checking bench for commit_trace_buffer: a scoreboard queue of expected records is compared at each handshake.
module tb_commit_trace_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cm_valid;
    logic [15:0] cm_pc, cm_inst, cm_wrdata, cm_memaddr, cm_memdata;
    logic        cm_regwrt, cm_memrd, cm_memwrt, cm_halt;
    logic [2:0]  cm_wrreg;
    logic        rec_valid, rec_ready;
    logic [2:0]  rec_kind, rec_reg;
    logic [31:0] rec_inum, rec_cycle, inst_count;
    logic [15:0] rec_pc, rec_wdata, rec_addr, rec_mdata;
    logic        overflow, err, done;

    typedef struct packed {
        logic [2:0]  kind;
        logic [31:0] inum;
        logic [15:0] pc;
        logic [2:0]  rg;
        logic [15:0] wdata;
        logic [15:0] addr;
        logic [15:0] mdata;
    } rec_t;

    rec_t        sb[$];
    logic [31:0] exp_count;
    int          total = 0;
    int          bad = 0;

    commit_trace_buffer #(.DEPTH(8), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .cm_valid(cm_valid), .cm_pc(cm_pc), .cm_inst(cm_inst),
        .cm_regwrt(cm_regwrt), .cm_wrreg(cm_wrreg), .cm_wrdata(cm_wrdata),
        .cm_memrd(cm_memrd), .cm_memwrt(cm_memwrt), .cm_memaddr(cm_memaddr),
        .cm_memdata(cm_memdata), .cm_halt(cm_halt),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_kind(rec_kind),
        .rec_inum(rec_inum), .rec_pc(rec_pc), .rec_reg(rec_reg),
        .rec_wdata(rec_wdata), .rec_addr(rec_addr), .rec_mdata(rec_mdata),
        .rec_cycle(rec_cycle), .inst_count(inst_count),
        .overflow(overflow), .err(err), .done(done)
    );

    always #5 clk = ~clk;

    // Scoreboard: every accepted head is checked against the oldest expected record.
    always @(negedge clk) begin
        if (!rst && rec_valid && rec_ready) begin
            rec_t got, exp_rec;
            got = '{rec_kind, rec_inum, rec_pc, rec_reg, rec_wdata, rec_addr, rec_mdata};
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_record: got inum=%0d kind=%0d, required no record", rec_inum, rec_kind);
            end else begin
                exp_rec = sb.pop_front();
                if (got !== exp_rec) begin
                    bad++;
                    $display("FAIL record: got %h required %h", got, exp_rec);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic rec_t model(input logic [15:0] pc, input logic rw, input logic [2:0] wr,
                                   input logic [15:0] wd, input logic rd, input logic mw,
                                   input logic [15:0] ma, input logic [15:0] md, input logic h,
                                   input logic [31:0] n);
        rec_t r = '0;
        r.pc = pc;
        r.inum = n;
        if (h)              r.kind = 3'd5;
        else if (rd && mw)  r.kind = 3'd7;
        else if (rw && mw)  begin r.kind = 3'd2; r.rg = wr; r.wdata = wd; r.addr = ma; r.mdata = md; end
        else if (rw && rd)  begin r.kind = 3'd1; r.rg = wr; r.wdata = wd; r.addr = ma; end
        else if (rw)        begin r.kind = 3'd0; r.rg = wr; r.wdata = wd; end
        else if (mw)        begin r.kind = 3'd3; r.addr = ma; r.mdata = md; end
        else                r.kind = 3'd4;
        return r;
    endfunction

    // Drives one commit cycle; records the expected trace entry when it should be accepted.
    task automatic send(input logic [15:0] pc, input logic rw, input logic [2:0] wr,
                        input logic [15:0] wd, input logic rd, input logic mw,
                        input logic [15:0] ma, input logic [15:0] md, input logic h,
                        input logic accept);
        cm_valid = 1'b1; cm_pc = pc; cm_inst = 16'($urandom);
        cm_regwrt = rw; cm_wrreg = wr; cm_wrdata = wd;
        cm_memrd = rd; cm_memwrt = mw; cm_memaddr = ma; cm_memdata = md; cm_halt = h;
        if (accept) begin
            sb.push_back(model(pc, rw, wr, wd, rd, mw, ma, md, h, exp_count));
            exp_count++;
        end
        step();
        cm_valid = 1'b0;
        cm_halt = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; cm_valid = 1'b0; rec_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        sb.delete();
        exp_count = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cm_valid = 1'b0; rec_ready = 1'b0; cm_halt = 1'b0;
        cm_pc = '0; cm_inst = '0; cm_regwrt = 1'b0; cm_wrreg = '0; cm_wrdata = '0;
        cm_memrd = 1'b0; cm_memwrt = 1'b0; cm_memaddr = '0; cm_memdata = '0;
        step();
        step();
        total++;
        if ({rec_valid, overflow, err, done, inst_count, rec_inum, rec_kind, rec_wdata, rec_cycle} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got valid=%b ovf=%b err=%b done=%b cnt=%0d inum=%0d kind=%0d, required all 0",
                     rec_valid, overflow, err, done, inst_count, rec_inum, rec_kind);
        end
        rst = 1'b0;
    endtask

    task automatic test_reg();
        do_reset();
        send(16'h0000, 1, 3'd3, 16'h1234, 0, 0, 16'h9999, 16'h8888, 0, 1);
        total++;
        if ({rec_valid, rec_kind, rec_inum, rec_reg, rec_wdata, rec_addr} !== {1'b1, 3'd0, 32'd0, 3'd3, 16'h1234, 16'h0000}) begin
            bad++;
            $display("FAIL reg_head: got valid=%b kind=%0d inum=%0d reg=%0d wdata=%h addr=%h, required 1 0 0 3 1234 0000",
                     rec_valid, rec_kind, rec_inum, rec_reg, rec_wdata, rec_addr);
        end
        rec_ready = 1'b1;
        step();
        rec_ready = 1'b0;
        total++;
        if ({rec_valid, rec_reg, rec_wdata} !== {1'b0, 3'd3, 16'h1234}) begin
            bad++;
            $display("FAIL empty_hold: got valid=%b reg=%0d wdata=%h, required 0 3 1234", rec_valid, rec_reg, rec_wdata);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        rec_ready = 1'b1;
        send(16'h0002, 1, 3'd2, 16'h5555, 1, 0, 16'h0040, 16'h7777, 0, 1);
        send(16'h0004, 1, 3'd5, 16'h0101, 0, 1, 16'h0080, 16'h2222, 0, 1);
        send(16'h0006, 0, 3'd6, 16'h7777, 0, 1, 16'h0010, 16'hBEEF, 0, 1);
        send(16'h0008, 0, 3'd1, 16'h3333, 0, 0, 16'h4444, 16'h6666, 0, 1);
        step();
        step();
        rec_ready = 1'b0;
        total++;
        if (inst_count !== 32'd4) begin
            bad++;
            $display("FAIL mixed_count: got %0d required 4", inst_count);
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL mixed_drained: got %0d records outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 8; i++)
            send(16'(16'h0100 + i), 1, 3'(i), 16'(16'hA000 + i), 0, 0, 16'h0, 16'h0, 0, 1);
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("FAIL full_no_overflow: got %b required 0", overflow);
        end
        send(16'h0200, 1, 3'd7, 16'hDEAD, 0, 0, 16'h0, 16'h0, 0, 0);
        total++;
        if ({overflow, inst_count, rec_valid} !== {1'b1, 32'd8, 1'b1}) begin
            bad++;
            $display("FAIL overflow: got ovf=%b cnt=%0d valid=%b, required 1 8 1", overflow, inst_count, rec_valid);
        end
        rec_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();
        rec_ready = 1'b0;
        total++;
        if ({rec_valid, overflow} !== 2'b01 || sb.size() != 0) begin
            bad++;
            $display("FAIL overflow_drain: got valid=%b ovf=%b outstanding=%0d, required 0 1 0", rec_valid, overflow, sb.size());
        end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 0; i < 8; i++)
            send(16'(16'h0300 + i), 0, 3'd0, 16'h0, 0, 1, 16'(16'h0400 + i), 16'(16'h0500 + i), 0, 1);
        rec_ready = 1'b1;
        send(16'h0308, 1, 3'd4, 16'hCAFE, 1, 0, 16'h0048, 16'h0, 0, 1);
        rec_ready = 1'b0;
        total++;
        if ({overflow, inst_count, rec_valid, rec_inum} !== {1'b0, 32'd9, 1'b1, 32'd1}) begin
            bad++;
            $display("FAIL push_pop_full: got ovf=%b cnt=%0d valid=%b head=%0d, required 0 9 1 1",
                     overflow, inst_count, rec_valid, rec_inum);
        end
        rec_ready = 1'b1;
        for (int i = 0; i < 7; i++) step();
        total++;
        if (rec_valid !== 1'b1 || rec_inum !== 32'd8) begin
            bad++;
            $display("FAIL occupancy: got valid=%b inum=%0d after 7 pops, required 1 8", rec_valid, rec_inum);
        end
        step();
        rec_ready = 1'b0;
        total++;
        if (rec_valid !== 1'b0 || sb.size() != 0) begin
            bad++;
            $display("FAIL push_pop_drain: got valid=%b outstanding=%0d, required 0 0", rec_valid, sb.size());
        end
    endtask

    task automatic test_halt();
        do_reset();
        for (int i = 0; i < 3; i++)
            send(16'(16'h0010 + i), 1, 3'(i + 1), 16'(16'h1000 + i), 0, 0, 16'h0, 16'h0, 0, 1);
        send(16'h0020, 1, 3'd2, 16'h4321, 0, 0, 16'h0, 16'h0, 1, 1);
        send(16'h0030, 1, 3'd1, 16'hAAAA, 0, 0, 16'h0, 16'h0, 0, 0);
        send(16'h0032, 0, 3'd0, 16'h0, 0, 1, 16'h0011, 16'h0022, 0, 0);
        total++;
        if ({inst_count, done} !== {32'd4, 1'b0}) begin
            bad++;
            $display("FAIL halt_ignore: got cnt=%0d done=%b, required 4 0", inst_count, done);
        end
        rec_ready = 1'b1;
        for (int i = 0; i < 3; i++)
            send(16'(16'h0040 + i), 1, 3'd1, 16'hBBBB, 0, 0, 16'h0, 16'h0, 0, 0);
        total++;
        if ({done, rec_kind, rec_pc} !== {1'b0, 3'd5, 16'h0020}) begin
            bad++;
            $display("FAIL halt_head: got done=%b kind=%0d pc=%h, required 0 5 0020", done, rec_kind, rec_pc);
        end
        send(16'h0050, 1, 3'd1, 16'hBBBB, 0, 0, 16'h0, 16'h0, 0, 0);
        total++;
        if ({done, rec_valid, inst_count} !== {1'b1, 1'b0, 32'd4}) begin
            bad++;
            $display("FAIL done: got done=%b valid=%b cnt=%0d, required 1 0 4", done, rec_valid, inst_count);
        end
        step();
        step();
        rec_ready = 1'b0;
        total++;
        if (done !== 1'b1 || sb.size() != 0) begin
            bad++;
            $display("FAIL done_sticky: got done=%b outstanding=%0d, required 1 0", done, sb.size());
        end
    endtask

    task automatic test_illegal_and_reset();
        do_reset();
        send(16'h0050, 0, 3'd2, 16'h1111, 1, 1, 16'h0044, 16'h0055, 0, 1);
        total++;
        if ({rec_kind, err} !== {3'd7, 1'b1}) begin
            bad++;
            $display("FAIL illegal: got kind=%0d err=%b, required 7 1", rec_kind, err);
        end
        send(16'h0052, 0, 3'd0, 16'h0, 0, 0, 16'h0, 16'h0, 1, 1);
        step();
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL drain_not_done: got %b required 0", done);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb.delete();
        exp_count = '0;
        total++;
        if ({rec_valid, done, inst_count, err, overflow} !== '0) begin
            bad++;
            $display("FAIL mid_reset: got valid=%b done=%b cnt=%0d err=%b ovf=%b, required all 0",
                     rec_valid, done, inst_count, err, overflow);
        end
        send(16'h0060, 1, 3'd6, 16'h6060, 0, 0, 16'h0, 16'h0, 0, 1);
        total++;
        if ({rec_valid, rec_inum, rec_kind} !== {1'b1, 32'd0, 3'd0}) begin
            bad++;
            $display("FAIL rerun: got valid=%b inum=%0d kind=%0d, required 1 0 0", rec_valid, rec_inum, rec_kind);
        end
        rec_ready = 1'b1;
        step();
        rec_ready = 1'b0;
    endtask

    task automatic test_cycle_stamp();
        logic [31:0] exp_cycle;
`ifdef COMMIT_TRACE_CYCLE_EN
        exp_cycle = 32'd4;
`else
        exp_cycle = 32'd0;
`endif
        do_reset();
        for (int i = 0; i < 4; i++) step();
        send(16'h0070, 1, 3'd1, 16'h0707, 0, 0, 16'h0, 16'h0, 0, 1);
        total++;
        if (rec_cycle !== exp_cycle) begin
            bad++;
            $display("FAIL cycle_stamp: got %0d required %0d", rec_cycle, exp_cycle);
        end
        rec_ready = 1'b1;
        step();
        rec_ready = 1'b0;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL final_drain: got %0d outstanding, required 0", sb.size());
        end
    endtask

    initial begin
        exp_count = '0;
        test_reset();
        test_reg();
        test_back_to_back();
        test_overflow();
        test_full_push_pop();
        test_halt();
        test_illegal_and_reset();
        test_cycle_stamp();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
